// File: rtl/tinyodin_obi_responder_if.sv
// OBI request/response bundle between the host bus initiator and the tinyODIN responder.
interface tinyodin_obi_responder_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/tinyodin_obi_responder.sv
// OBI slave responder for tinyODIN: decodes word accesses into spike, neuron and
// synapse SRAM strobes plus one control register, with a single-stage response.
module tinyodin_obi_responder #(
    parameter int unsigned N        = 256,
    parameter int unsigned SPK_AW   = 6,
    parameter int unsigned NEU_AW   = 8,
    parameter int unsigned SYN_AW   = 13,
    parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    tinyodin_obi_responder_if.slave obi,
    output logic                   spk_cs_o,
    output logic                   spk_we_o,
    output logic [SPK_AW-1:0]      spk_addr_o,
    output logic                   neu_cs_o,
    output logic                   neu_we_o,
    output logic [NEU_AW-1:0]      neu_addr_o,
    output logic                   syn_cs_o,
    output logic                   syn_we_o,
    output logic [SYN_AW-1:0]      syn_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            spk_rdata_i,
    input  logic [31:0]            neu_rdata_i,
    input  logic [31:0]            syn_rdata_i,
    input  logic                   core_busy_i,
    output logic [31:0]            ctrl_o,
    output logic                   start_o
);

    typedef enum logic [2:0] {
        REG_SPK,
        REG_NEU,
        REG_SYN,
        REG_CTRL,
        REG_ERR
    } region_e;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_e;

    // Neuron words beyond N alias back into the populated part of the SRAM.
    localparam logic [NEU_AW-1:0] NEU_MASK = NEU_AW'(N - 1);

    region_e     region;
    logic        is_mem;
    logic        gnt;
    logic        accept;

    state_e      state_q, state_d;
    region_e     rsp_region_q, rsp_region_d;
    logic        rsp_we_q, rsp_we_d;
    logic [31:0] ctrl_snap_q, ctrl_snap_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic        start_q, start_d;

    // Byte enables and address bits outside every region are don't-care.
    logic        addr_unused;
    assign addr_unused = ^{obi.be, obi.addr[19:SYN_AW+2], obi.addr[1:0]};

    // Region decode from the byte address.
    always_comb begin
        region = REG_ERR;
        if (obi.addr[31:22] == 10'd0) begin
            case (obi.addr[21:20])
                2'b00: region = REG_SPK;
                2'b01: region = REG_NEU;
                2'b10: region = REG_SYN;
                2'b11: region = REG_CTRL;
            endcase
        end
    end

    // Grant and SRAM strobes; memories are stalled while the core owns them.
    always_comb begin
        is_mem     = (region == REG_SPK) || (region == REG_NEU) || (region == REG_SYN);
        gnt        = ~RST & obi.req & ~(core_busy_i & is_mem);
        accept     = gnt;
        spk_cs_o   = accept & (region == REG_SPK);
        neu_cs_o   = accept & (region == REG_NEU);
        syn_cs_o   = accept & (region == REG_SYN);
        spk_we_o   = spk_cs_o & obi.we;
        neu_we_o   = neu_cs_o & obi.we;
        syn_we_o   = syn_cs_o & obi.we;
        spk_addr_o = obi.addr[SPK_AW+1:2];
        neu_addr_o = obi.addr[NEU_AW+1:2] & NEU_MASK;
        syn_addr_o = obi.addr[SYN_AW+1:2];
    end

    assign obi.gnt     = gnt;
    assign mem_wdata_o = obi.wdata;
    assign ctrl_o      = ctrl_q;
    assign start_o     = start_q;

    // Response FSM: RESP holds while accepts keep arriving back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)  state_d = S_RESP;
            S_RESP: if (!accept) state_d = S_IDLE;
        endcase
    end

    // Capture what the response cycle needs; control writes update ctrl and start.
    always_comb begin
        rsp_region_d = rsp_region_q;
        rsp_we_d     = rsp_we_q;
        ctrl_snap_d  = ctrl_snap_q;
        ctrl_d       = ctrl_q;
        start_d      = 1'b0;
        if (accept) begin
            rsp_region_d = region;
            rsp_we_d     = obi.we;
            ctrl_snap_d  = {ctrl_q[31:11], core_busy_i, ctrl_q[9:0]};
            if (obi.we && (region == REG_CTRL)) begin
                ctrl_d  = {obi.wdata[31:11], 1'b0, obi.wdata[9:0]};
                start_d = obi.wdata[10] & ~core_busy_i;
            end
        end
    end

    // Control state: FSM, control register and start pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ctrl_q  <= 32'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            start_q <= start_d;
        end
    end

    // ---- response stage p1: tag, direction and ctrl snapshot (data, no reset) ----
    always_ff @(posedge CLK) begin
        rsp_region_q <= rsp_region_d;
        rsp_we_q     <= rsp_we_d;
        ctrl_snap_q  <= ctrl_snap_d;
    end

    // Response data select; zero outside the response cycle and for writes.
    always_comb begin
        obi.rvalid = (state_q == S_RESP);
        obi.rdata  = 32'd0;
        if ((state_q == S_RESP) && !rsp_we_q) begin
            case (rsp_region_q)
                REG_SPK:  obi.rdata = spk_rdata_i;
                REG_NEU:  obi.rdata = neu_rdata_i;
                REG_SYN:  obi.rdata = syn_rdata_i;
                REG_CTRL: obi.rdata = ctrl_snap_q;
                default:  obi.rdata = ERR_WORD;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyodin_obi_responder.sv
// Bench for tinyodin_obi_responder: directed scenarios followed by random traffic,
// all checked against a word-level model of the address map and control register.
module tb_tinyodin_obi_responder;
    localparam int SPK_AW = 6;
    localparam int NEU_AW = 8;
    localparam int SYN_AW = 13;

    logic                CLK = 1'b0;
    logic                RST;
    logic                spk_cs, spk_we, neu_cs, neu_we, syn_cs, syn_we;
    logic [SPK_AW-1:0]   spk_addr;
    logic [NEU_AW-1:0]   neu_addr;
    logic [SYN_AW-1:0]   syn_addr;
    logic [31:0]         mem_wdata, spk_rd, neu_rd, syn_rd, ctrl;
    logic                core_busy, start;

    int n_checks = 0;
    int n_errors = 0;

    // Environment SRAMs (driven by the DUT strobes).
    logic [31:0] spk_mem [64]   = '{default: '0};
    logic [31:0] neu_mem [256]  = '{default: '0};
    logic [31:0] syn_mem [8192] = '{default: '0};

    // Reference model state.
    logic [31:0] ref_spk [64]   = '{default: '0};
    logic [31:0] ref_neu [256]  = '{default: '0};
    logic [31:0] ref_syn [8192] = '{default: '0};
    logic        exp_rv   = 1'b0;
    logic        exp_st   = 1'b0;
    logic [31:0] exp_rd   = '0;
    logic [31:0] exp_ctrl = '0;
    logic        last_acc = 1'b0;
    logic        hold     = 1'b0;

    always #5 CLK = ~CLK;

    tinyodin_obi_responder_if obi ();

    tinyodin_obi_responder dut (
        .CLK         (CLK),
        .RST         (RST),
        .obi         (obi),
        .spk_cs_o    (spk_cs),
        .spk_we_o    (spk_we),
        .spk_addr_o  (spk_addr),
        .neu_cs_o    (neu_cs),
        .neu_we_o    (neu_we),
        .neu_addr_o  (neu_addr),
        .syn_cs_o    (syn_cs),
        .syn_we_o    (syn_we),
        .syn_addr_o  (syn_addr),
        .mem_wdata_o (mem_wdata),
        .spk_rdata_i (spk_rd),
        .neu_rdata_i (neu_rd),
        .syn_rdata_i (syn_rd),
        .core_busy_i (core_busy),
        .ctrl_o      (ctrl),
        .start_o     (start)
    );

    always @(posedge CLK) begin
        if (spk_cs) begin
            if (spk_we) spk_mem[spk_addr] <= mem_wdata;
            else        spk_rd <= spk_mem[spk_addr];
        end
        if (neu_cs) begin
            if (neu_we) neu_mem[neu_addr] <= mem_wdata;
            else        neu_rd <= neu_mem[neu_addr];
        end
        if (syn_cs) begin
            if (syn_we) syn_mem[syn_addr] <= mem_wdata;
            else        syn_rd <= syn_mem[syn_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // 0..2 = memories, 3 = control register, 4 = undecoded.
    function automatic int region_of(input logic [31:0] a);
        if ((a >> 22) != 0) return 4;
        return int'((a >> 20) & 32'h3);
    endfunction

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        obi.req   = req;
        obi.we    = we;
        obi.addr  = addr;
        obi.wdata = wdata;
        obi.be    = 4'($urandom);
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        logic [31:0] a, wd, ns, nn, ny, nrd, nctrl;
        logic        g, nrv, nst;
        int          r;
        @(negedge CLK);
        a  = obi.addr;
        wd = obi.wdata;
        r  = region_of(a);
        ns = (a >> 2) & ((32'd1 << SPK_AW) - 1);
        nn = (a >> 2) & ((32'd1 << NEU_AW) - 1);
        ny = (a >> 2) & ((32'd1 << SYN_AW) - 1);
        g  = !RST && obi.req && !(core_busy && r < 3);
        chk("gnt", 32'(obi.gnt), 32'(g));
        chk("spk_cs", 32'(spk_cs), 32'(g && r == 0));
        chk("neu_cs", 32'(neu_cs), 32'(g && r == 1));
        chk("syn_cs", 32'(syn_cs), 32'(g && r == 2));
        chk("mem_wdata", mem_wdata, wd);
        if (g && r == 0) begin
            chk("spk_we", 32'(spk_we), 32'(obi.we));
            chk("spk_addr", 32'(spk_addr), ns);
        end
        if (g && r == 1) begin
            chk("neu_we", 32'(neu_we), 32'(obi.we));
            chk("neu_addr", 32'(neu_addr), nn);
        end
        if (g && r == 2) begin
            chk("syn_we", 32'(syn_we), 32'(obi.we));
            chk("syn_addr", 32'(syn_addr), ny);
        end
        chk("rvalid", 32'(obi.rvalid), 32'(exp_rv));
        chk("rdata", obi.rdata, exp_rd);
        chk("start", 32'(start), 32'(exp_st));
        chk("ctrl", ctrl, exp_ctrl);

        nrv = 1'b0; nrd = '0; nst = 1'b0; nctrl = exp_ctrl;
        if (!RST) begin
            nrv = g;
            if (g && obi.we) begin
                case (r)
                    0: ref_spk[ns] = wd;
                    1: ref_neu[nn] = wd;
                    2: ref_syn[ny] = wd;
                    3: begin
                        nctrl = wd & ~32'h0000_0400;
                        nst   = wd[10] && !core_busy;
                    end
                    default: ;
                endcase
            end else if (g) begin
                case (r)
                    0: nrd = ref_spk[ns];
                    1: nrd = ref_neu[nn];
                    2: nrd = ref_syn[ny];
                    3: nrd = (exp_ctrl & ~32'h0000_0400) | (core_busy ? 32'h0000_0400 : 32'h0);
                    default: nrd = 32'hDEAD_BEEF;
                endcase
            end
        end else begin
            nctrl = '0;
        end
        exp_rv   = nrv;
        exp_rd   = nrd;
        exp_st   = nst;
        exp_ctrl = nctrl;
        last_acc = g;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST       = 1'b1;
        core_busy = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        step();
        step();
        chk("rst_rvalid", 32'(obi.rvalid), 32'd0);
        chk("rst_ctrl", ctrl, 32'd0);
        RST = 1'b0;

        // Neuron write.
        drive(1'b1, 1'b1, 32'h0010_0014, 32'h0015_E000);
        step();
        chk("t1_rvalid", 32'(obi.rvalid), 32'd1);
        chk("t1_rdata", obi.rdata, 32'd0);

        // Spike write then read back word 35.
        drive(1'b1, 1'b1, 32'h0000_008C, 32'hA5A5_0001);
        step();
        drive(1'b1, 1'b0, 32'h0000_008C, 32'h0);
        step();
        chk("t2_rdata", obi.rdata, 32'hA5A5_0001);

        // Synapse write then read, back to back.
        drive(1'b1, 1'b1, 32'h0020_4878, 32'h1357_9BDF);
        step();
        drive(1'b1, 1'b0, 32'h0020_4878, 32'h0);
        step();
        chk("t3_rdata", obi.rdata, 32'h1357_9BDF);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Busy stall on a neuron read, then release.
        core_busy = 1'b1;
        drive(1'b1, 1'b0, 32'h0010_0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stalled", 32'(obi.rvalid), 32'd0);
        end
        core_busy = 1'b0;
        step();
        chk("t4_rvalid", 32'(obi.rvalid), 32'd1);

        // Control register writes, idle then busy, and a busy read.
        drive(1'b1, 1'b1, 32'h0030_0000, 32'hFF00_0400);
        step();
        chk("t5_ctrl", ctrl, 32'hFF00_0000);
        chk("t5_start", 32'(start), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("t5_start_end", 32'(start), 32'd0);
        core_busy = 1'b1;
        drive(1'b1, 1'b1, 32'h0030_0000, 32'hFF00_0400);
        step();
        chk("t5_busy_start", 32'(start), 32'd0);
        drive(1'b1, 1'b0, 32'h0030_0000, 32'h0);
        step();
        chk("t5_rdata", obi.rdata, 32'hFF00_0400);
        core_busy = 1'b0;

        // Undecoded read, then reset during a response.
        drive(1'b1, 1'b0, 32'h0040_0000, 32'h0);
        step();
        chk("t6_err", obi.rdata, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 32'h0030_0000, 32'h1234_5678);
        step();
        RST = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("t6_rvalid", 32'(obi.rvalid), 32'd0);
        chk("t6_ctrl", ctrl, 32'd0);
        chk("t6_start", 32'(start), 32'd0);
        RST = 1'b0;

        // Random traffic; an ungranted request is held unchanged.
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                int          rg;
                logic [31:0] a;
                rg = $urandom_range(0, 4);
                if (rg == 4) a = $urandom | 32'h0040_0000;
                else         a = (32'(rg) << 20) | ($urandom & 32'h000F_FFFF);
                drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom);
            end
            core_busy = ($urandom_range(0, 3) == 0);
            RST       = ($urandom_range(0, 59) == 0);
            step();
            hold = obi.req && !last_acc && !RST;
        end
        RST = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
